// File: rtl/uart_rx.sv
// UART 8N1 receive front end: synchronises the RX pin, samples each bit at mid-period
// and writes {frame_err, data} into a downstream FIFO. It never writes into a full FIFO.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_fifo_full,
  output logic       o_wr_en,
  output logic [8:0] o_wr_data,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(HALF_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [2:0]           bit_idx_reg;
  logic [7:0]           shift_reg;
  logic                 rx_meta_reg;
  logic                 rx_s_reg;
  logic                 rx_prev_reg;
  logic                 wr_en_reg;
  logic [8:0]           wr_data_reg;
  logic                 overrun_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
      wr_en_reg   <= 1'b0;
      overrun_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // Edge-triggered only, so a line stuck low (break) cannot retrigger.
          if (rx_prev_reg && !rx_s_reg) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end

        START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg <= '0;
            if (!rx_s_reg) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg                <= '0;
            shift_reg[bit_idx_reg] <= rx_s_reg;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        STOP: begin
          // Leave at the stop-bit midpoint so a following start edge is not missed.
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            if (!i_fifo_full) begin
              wr_en_reg   <= 1'b1;
              wr_data_reg <= {~rx_s_reg, shift_reg};
            end else begin
              overrun_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_wr_en   = wr_en_reg;
  assign o_wr_data = wr_data_reg;
  assign o_overrun = overrun_reg;
  assign o_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a monitor logs every FIFO write
// and overrun pulse, and each scenario task checks the log against hand-computed values.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int HALF = CPB / 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       fifo_full;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] wr_q[$];
  int         ovr_cnt  = 0;
  int         both_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .i_fifo_full (fifo_full),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data),
    .o_overrun   (overrun),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back(wr_data);
      $display("write  data=0x%03h", wr_data);
    end
    if (overrun) begin
      ovr_cnt++;
      $display("overrun pulse");
    end
    if (wr_en && overrun) both_cnt++;
  end

  task automatic bit_time(input logic val);
    rx = val;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop);
    $display("send   data=0x%02h stop=%0d", data, stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(data[i]);
    bit_time(stop);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    rx = 1'b1;
    fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0 || wr_data !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs: wr_en=%b overrun=%b busy=%b wr_data=0x%03h, expected 0/0/0/0x000",
               wr_en, overrun, busy, wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (wr_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: writes=%0d busy=%b, expected 0/0", wr_q.size(), busy);
    end
  endtask

  task automatic test_basic;
    wr_q.delete();
    send_byte(8'hA5, 1'b1);
    idle(2);
    checks++;
    if (wr_q.size() != 1) begin
      errors++;
      $display("FAIL basic_count: writes=%0d, expected 1", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 9'h0A5) begin
        errors++;
        $display("FAIL basic_data: got 0x%03h, expected 0x0A5", wr_q[0]);
      end
    end
    checks++;
    if (ovr_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: overruns=%0d busy=%b, expected 0/0", ovr_cnt, busy);
    end
  endtask

  task automatic test_frame_err_break;
    wr_q.delete();
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    checks++;
    if (wr_q.size() != 1) begin
      errors++;
      $display("FAIL break_count: writes=%0d, expected 1", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 9'h13C) begin
        errors++;
        $display("FAIL frame_err_data: got 0x%03h, expected 0x13C", wr_q[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL break_busy: busy=%b during held-low line, expected 0", busy);
    end
    idle(2);
    send_byte(8'h5A, 1'b1);
    idle(2);
    checks++;
    if (wr_q.size() != 2 || wr_q[wr_q.size()-1] !== 9'h05A) begin
      errors++;
      $display("FAIL after_break: writes=%0d last=0x%03h, expected 2 writes ending 0x05A",
               wr_q.size(), wr_q[wr_q.size()-1]);
    end
  endtask

  task automatic test_glitch;
    int busy_cycles;
    wr_q.delete();
    busy_cycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) rx = 1'b1;
      if (busy) busy_cycles++;
    end
    $display("glitch busy_cycles=%0d", busy_cycles);
    checks++;
    if (busy_cycles < 1 || busy_cycles > HALF + 1) begin
      errors++;
      $display("FAIL glitch_busy: busy for %0d cycles, expected 1..%0d", busy_cycles, HALF + 1);
    end
    checks++;
    if (wr_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_write: writes=%0d busy=%b, expected 0/0", wr_q.size(), busy);
    end
  endtask

  task automatic test_overrun;
    wr_q.delete();
    ovr_cnt = 0;
    fifo_full = 1'b1;
    send_byte(8'h55, 1'b1);
    idle(2);
    checks++;
    if (wr_q.size() != 0 || ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_full: writes=%0d overruns=%0d, expected 0/1", wr_q.size(), ovr_cnt);
    end
    fifo_full = 1'b0;
    send_byte(8'h66, 1'b1);
    idle(2);
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 9'h066 || ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_release: writes=%0d data=0x%03h overruns=%0d, expected 1/0x066/1",
               wr_q.size(), wr_q[0], ovr_cnt);
    end
  endtask

  task automatic test_back_to_back;
    wr_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(2);
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d, expected 2", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 9'h000 || wr_q[1] !== 9'h0FF) begin
        errors++;
        $display("FAIL b2b_data: got 0x%03h,0x%03h expected 0x000,0x0FF", wr_q[0], wr_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h81;
    wr_q.delete();
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(d[i]);
    rx = d[3];
    repeat (HALF) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0 || wr_data !== 9'h000) begin
      errors++;
      $display("FAIL async_reset: wr_en=%b overrun=%b busy=%b wr_data=0x%03h, expected 0/0/0/0x000",
               wr_en, overrun, busy, wr_data);
    end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    idle(12);
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_discard: writes=%0d, expected 0", wr_q.size());
    end
    send_byte(8'h42, 1'b1);
    idle(2);
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 9'h042) begin
      errors++;
      $display("FAIL reset_resume: writes=%0d data=0x%03h, expected 1/0x042", wr_q.size(), wr_q[0]);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    rx = 1'b1;
    fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_err_break();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL exclusive_strobes: %0d cycles with wr_en and overrun both high, expected 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
